input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive synchronized cycles a new level must hold before q follows; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 8: width of the stability counter.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port d  input  1: raw asynchronous, bouncy level from pin or button.
REQ-006 SHALL have port q  output  1: debounced, synchronized level; drives the d input of the downstream edge_detector.
REQ-007 SHALL have port busy  output  1: high while a candidate level change is being qualified (counter non-zero).

Function
REQ-008 SHALL pass d through a 2-flop synchronizer (s1, s2); only s2 is used by the debounce logic.
REQ-009 SHALL hold CNT_W-bit counter cnt; q and busy registered, no combinational path from d to q.
REQ-010 SHALL clear cnt to 0 at each edge where s2 == q (idle, or glitch ended mid-count).
REQ-011 SHALL increment cnt at each edge where s2 != q and cnt < STABLE_CYCLES-1.
REQ-012 SHALL, at the edge where s2 != q and cnt == STABLE_CYCLES-1, load q <= s2 and cnt <= 0 in the same edge.
REQ-013 SHALL give latency: d level first sampled into s1 at edge N and held -> q updates at edge N+1+STABLE_CYCLES.
REQ-014 SHALL drive busy = (cnt != 0), registered alongside cnt; busy low on the edge q updates.
REQ-015 SHALL restart qualification from 0 on any bounce (s2 returning to q), never accumulating across bounces.
REQ-016 SHALL never wrap cnt; cnt max value is STABLE_CYCLES-1.
REQ-017 SHALL treat STABLE_CYCLES=1 as sync-only: q follows s2 one edge later, busy always 0.
REQ-018 SHALL change q at most once per STABLE_CYCLES edges.

Reset
REQ-019 SHALL asynchronously clear s1, s2, cnt, q, busy to 0 while rst=1, independent of clk.
REQ-020 SHALL abort any in-progress qualification on reset; no q toggle caused by pre-reset history.
REQ-021 SHALL, if d=1 at reset release, raise q per REQ-013 counting from the first sampling edge after release.

Configuration
REQ-022 SHALL support macro SYNC_STAGE3_EN: when defined, synchronizer is 3 flops (s1, s2, s3) with s3 feeding the debounce logic and latency becomes N+2+STABLE_CYCLES; when undefined, 2-flop chain per REQ-008/REQ-013.
REQ-023 SHALL reset the extra stage with the others when SYNC_STAGE3_EN is defined.

Verification (STABLE_CYCLES=4, CNT_W=8, macro undefined unless stated)
REQ-024 SHALL cover: rst=1 with d=1, clk running -> q=0, busy=0 throughout; rst asserted between edges -> outputs clear immediately.
REQ-025 SHALL cover: d 0->1 sampled at edge N, held 8 cycles -> busy=1 after edges N+2..N+4, q=1 after edge N+5, busy=0.
REQ-026 SHALL cover: d=1 for 3 cycles then 0 -> q stays 0, busy returns to 0, cnt=0.
REQ-027 SHALL cover: bounce d=1,0,1,0,1 one cycle each then hold 1 (final rise sampled at edge M) -> q=1 exactly after edge M+5, no earlier.
REQ-028 SHALL cover: rst pulsed while cnt=2 with d held 1 -> q=0 and cnt=0 during reset; after release q=1 at first sample edge+5.
REQ-029 SHALL cover: SYNC_STAGE3_EN defined, repeat REQ-025 -> q=1 after edge N+6; 1->0 transition symmetric.

Source files
------------

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Synchronizes a raw, bouncy level (pin or push button) into the clk domain
// and only lets the debounced output q follow once the synchronized level has
// differed from q for STABLE_CYCLES consecutive edges. Any return of the
// synchronized level to q during qualification restarts the count from zero.
//
// Parameters
//   STABLE_CYCLES : edges a new level must hold before q follows (1..2^CNT_W-1).
//                   A value of 1 makes the block a plain synchronizer.
//   CNT_W         : width of the stability counter.
//
// Ports
//   clk  : single clock, all state updates on the rising edge.
//   rst  : asynchronous, active-high reset; clears every flop.
//   d    : raw asynchronous input level.
//   q    : debounced, synchronized level (registered).
//   busy : high while a candidate level change is being qualified
//          (stability counter non-zero), registered alongside the counter.
//
// Configuration
//   SYNC_STAGE3_EN : when defined, the synchronizer is three flops deep
//                    (s1, s2, s3) and s3 feeds the debounce logic, adding one
//                    edge of latency. When undefined, a two-flop chain is used.
//
// No handshake: d is a free-running level and q/busy are plain levels.
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic busy
);

  // Last counter value before q is allowed to update.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
`ifdef SYNC_STAGE3_EN
  logic             s3_q, s3_d;
`endif
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             busy_q, busy_d;

  // Level seen by the debounce logic: the last synchronizer stage.
  logic             sync_lvl;

`ifdef SYNC_STAGE3_EN
  assign sync_lvl = s3_q;
`else
  assign sync_lvl = s2_q;
`endif

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
`ifdef SYNC_STAGE3_EN
    s3_d   = s2_q;
`endif
    cnt_d  = '0;
    q_d    = q_q;

    if (sync_lvl == q_q) begin
      // Idle, or a bounce ended the candidate change: start over.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Level held long enough: follow it and rearm in the same edge.
      q_d   = sync_lvl;
      cnt_d = '0;
    end else begin
      // Saturates at CNT_LAST by construction, so the counter never wraps.
      cnt_d = cnt_q + CNT_ONE;
    end

    // busy is registered from the next counter value so it tracks cnt_q
    // exactly and is low on the edge where q updates.
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
`ifdef SYNC_STAGE3_EN
      s3_q   <= 1'b0;
`endif
      cnt_q  <= '0;
      q_q    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
`ifdef SYNC_STAGE3_EN
      s3_q   <= s3_d;
`endif
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      busy_q <= busy_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;

endmodule
